func_sweep_tester: RTL and testbench
====================================

// Module: func_sweep_tester
// PURPOSE
//  Stimulus/capture stage wrapped around the 3-input logic-function block (f = x | (~y & z)).
//  On start, drives all 8 {x,y,z} vectors in ascending order and samples f after a settle delay.
//  Builds an 8-bit truth table, compares it to an expected table, and reports pass/fail.
//  Sits directly upstream (drives x,y,z) and downstream (consumes f) of the function block.
// PARAMETERS
//  SETTLE_CYCLES  2      cycles vector is held before the sample cycle (0..15)
//  EXPECTED       8'hF2  golden table; bit i = f for {x,y,z}=i
// PORTS
//  clk         in   1  single clock, rising edge
//  rst         in   1  synchronous, active-high reset
//  start       in   1  one-cycle request; accepted only in IDLE
//  f_in        in   1  output of function block under test
//  x_out       out  1  drive to x (MSB of vector index)
//  y_out       out  1  drive to y
//  z_out       out  1  drive to z (LSB)
//  busy        out  1  high from the cycle after start acceptance until done
//  done        out  1  one-cycle pulse when sweep completes
//  pass        out  1  table == EXPECTED; valid from done, held until next start
//  table_out   out  8  captured truth table, held until next start
//  mism_cnt    out  4  number of mismatching vectors (0..8)
// BEHAVIOUR
//  - Reset: state=IDLE; x/y/z_out=0, busy=0, done=0, pass=0, table_out=0, mism_cnt=0.
//  - FSM: IDLE -> SETTLE -> SAMPLE -> (SETTLE for next idx | DONE) -> IDLE.
//  - IDLE: start=1 at cycle T -> clear table_out, mism_cnt, pass; idx=0; goto SETTLE.
//    x/y/z_out = idx[2:0] registered; valid from T+1.
//  - SETTLE: count SETTLE_CYCLES cycles; SETTLE_CYCLES=0 -> go straight to SAMPLE (SETTLE skipped).
//  - SAMPLE (one cycle): table_out[idx] <= f_in; if f_in != EXPECTED[idx], mism_cnt += 1.
//    idx<7 -> idx+1, vector updates next cycle, goto SETTLE; idx==7 -> goto DONE.
//  - Each vector occupies SETTLE_CYCLES+1 cycles; done high at cycle T+1+8*(SETTLE_CYCLES+1).
//  - DONE (one cycle): done=1, busy=0, pass=(mism_cnt==0) including the final sample; goto IDLE.
//  - Vector outputs hold 3'b111 after the sweep until the next start.
//  - start outside IDLE (including DONE): ignored, no queuing.
//  - rst mid-sweep: immediate return to reset values; partial results discarded.
//  - idx is 3 bits and never wraps within a sweep; mism_cnt is 4 bits to hold 8.
// CONFIGURATION
//  FUNC_SWEEP_FIRST_FAIL_EN defined: adds ports first_fail_vld (out,1) and first_fail_idx (out,3).
//    Both are cleared at start; on the first mismatching SAMPLE, latch idx and set vld=1.
//    Both hold until the next start or rst.
//  Not defined: those ports and their registers do not exist; all other behaviour is unchanged.
// STRUCTURE
//  Shared include func_sweep_defs.vh:
//    - FSM state encodings ST_IDLE/ST_SETTLE/ST_SAMPLE/ST_DONE (2 bits)
//    - default golden table FUNC_TT_GOLDEN = 8'hF2
//  One sub-module sweep_settle_timer: load on vector change; asserts expire after SETTLE_CYCLES.
//  Everything else is inline in func_sweep_tester.
// TESTING
//  1 Correct DUT, SETTLE_CYCLES=2, start pulse -> vectors 0..7 each held 3 cycles;
//    done at T+25; table_out=8'hF2, pass=1, mism_cnt=0.
//  2 DUT with f stuck at 0 -> table_out=8'h00, mism_cnt=5, pass=0;
//    with FIRST_FAIL_EN: first_fail_idx=1, first_fail_vld=1.
//  3 SETTLE_CYCLES=0 -> one cycle per vector, done at T+9, table_out=8'hF2.
//  4 start re-pulsed during busy at idx=3, and again on the done cycle
//    -> both ignored; a single done pulse; results unchanged.
//  5 rst asserted during SAMPLE of idx=5 -> next cycle all outputs at reset values;
//    a new start gives a full, clean sweep.
//  6 Two back-to-back sweeps, faulty DUT then correct DUT
//    -> second sweep clears stale table, count and first-fail; ends with pass=1.

Source files
------------

// File: rtl/func_sweep_tester_pkg.sv
// Shared definitions for the truth-table sweep stage: FSM state encodings,
// the default golden table, and a helper that picks the per-vector entry state.
package func_sweep_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    // Truth table of f = x | (~y & z); bit i is f for {x,y,z} = i.
    localparam logic [7:0] FUNC_TT_GOLDEN = 8'hF2;

    // With no settle time there is nothing to wait for, so a new vector goes straight to SAMPLE.
    function automatic sweep_state_e vec_entry_state(input int unsigned settle_cycles);
        if (settle_cycles == 32'd0) begin
            return ST_SAMPLE;
        end else begin
            return ST_SETTLE;
        end
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle-delay counter: reloaded whenever a new vector is driven, flags expiry on
// the last of SETTLE_CYCLES enabled cycles.
module sweep_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [3:0] LAST_CNT = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    logic [3:0] cnt_r;

    // Settle cycle counter, restarted on every vector change
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (load) begin
            cnt_r <= 4'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/func_sweep_tester.sv
// Sweeps all eight {x,y,z} vectors into the function block, captures f into a
// truth table and grades it. Optional FUNC_SWEEP_FIRST_FAIL_EN adds first-failure capture.
module func_sweep_tester
    import func_sweep_tester_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECTED      = FUNC_TT_GOLDEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f_in,
    output logic       x_out,
    output logic       y_out,
    output logic       z_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] table_out,
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
    output logic       first_fail_vld,
    output logic [2:0] first_fail_idx,
`endif
    output logic [3:0] mism_cnt
);

    localparam sweep_state_e VEC_ENTRY_ST = vec_entry_state(SETTLE_CYCLES);

    sweep_state_e state_r, state_nx;
    logic [2:0]   idx_r, idx_nx;
    logic [7:0]   table_r, table_nx;
    logic [3:0]   mism_r, mism_nx;
    logic         busy_r, busy_nx;
    logic         done_r, done_nx;
    logic         pass_r, pass_nx;
    logic         load_s;
    logic         expire_s;
    logic         settle_en_s;
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
    logic         ff_vld_r, ff_vld_nx;
    logic [2:0]   ff_idx_r, ff_idx_nx;
`endif

    assign settle_en_s = (state_r == ST_SETTLE);

    sweep_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .en     (settle_en_s),
        .expire (expire_s)
    );

    // Next-state and result-update logic for the sweep
    always_comb begin
        state_nx = state_r;
        idx_nx   = idx_r;
        table_nx = table_r;
        mism_nx  = mism_r;
        pass_nx  = pass_r;
        load_s   = 1'b0;
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
        ff_vld_nx = ff_vld_r;
        ff_idx_nx = ff_idx_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    idx_nx   = 3'd0;
                    table_nx = 8'd0;
                    mism_nx  = 4'd0;
                    pass_nx  = 1'b0;
                    load_s   = 1'b1;
                    state_nx = VEC_ENTRY_ST;
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
                    ff_vld_nx = 1'b0;
                    ff_idx_nx = 3'd0;
`endif
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (expire_s) begin
                    state_nx = ST_SAMPLE;
                end else begin
                    state_nx = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                table_nx[idx_r] = f_in;
                if (f_in != EXPECTED[idx_r]) begin
                    mism_nx = mism_r + 4'd1;
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
                    if (!ff_vld_r) begin
                        ff_vld_nx = 1'b1;
                        ff_idx_nx = idx_r;
                    end else begin
                        ff_vld_nx = ff_vld_r;
                    end
`endif
                end else begin
                    mism_nx = mism_r;
                end
                // Final vector: grade including the sample taken this cycle.
                if (idx_r == 3'd7) begin
                    pass_nx  = (mism_nx == 4'd0);
                    state_nx = ST_DONE;
                end else begin
                    idx_nx   = idx_r + 3'd1;
                    load_s   = 1'b1;
                    state_nx = VEC_ENTRY_ST;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        busy_nx = (state_nx == ST_SETTLE) || (state_nx == ST_SAMPLE);
        done_nx = (state_nx == ST_DONE);
    end

    // State, vector and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 3'd0;
            table_r <= 8'd0;
            mism_r  <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
            ff_vld_r <= 1'b0;
            ff_idx_r <= 3'd0;
`endif
        end else begin
            state_r <= state_nx;
            idx_r   <= idx_nx;
            table_r <= table_nx;
            mism_r  <= mism_nx;
            busy_r  <= busy_nx;
            done_r  <= done_nx;
            pass_r  <= pass_nx;
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
            ff_vld_r <= ff_vld_nx;
            ff_idx_r <= ff_idx_nx;
`endif
        end
    end

    // The vector index register drives the function block directly.
    assign x_out     = idx_r[2];
    assign y_out     = idx_r[1];
    assign z_out     = idx_r[0];
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign table_out = table_r;
    assign mism_cnt  = mism_r;
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
    assign first_fail_vld = ff_vld_r;
    assign first_fail_idx = ff_idx_r;
`endif

endmodule

// File: tb/tb_func_sweep_tester.sv
// Bench for func_sweep_tester: two instances (settle 2 and settle 0) each wrapped
// around a behavioural function block with selectable faults.
module tb_func_sweep_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start2, start0;
    logic [1:0] mode2, mode0;
    logic       f2, x2, y2, z2, busy2, done2, pass2;
    logic       f0, x0, y0, z0, busy0, done0, pass0;
    logic [7:0] table2, table0;
    logic [3:0] mism2, mism0;
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
    logic       ffv2, ffv0;
    logic [2:0] ffi2, ffi0;
`endif

    // mode: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
    function automatic logic fmodel(input logic x, input logic y, input logic z, input logic [1:0] mode);
        case (mode)
            2'd0:    return x | (~y & z);
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return ~(x | (~y & z));
        endcase
    endfunction

    assign f2 = fmodel(x2, y2, z2, mode2);
    assign f0 = fmodel(x0, y0, z0, mode0);

    func_sweep_tester #(.SETTLE_CYCLES(2), .EXPECTED(8'hF2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .f_in(f2),
        .x_out(x2), .y_out(y2), .z_out(z2), .busy(busy2), .done(done2),
        .pass(pass2), .table_out(table2),
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
        .first_fail_vld(ffv2), .first_fail_idx(ffi2),
`endif
        .mism_cnt(mism2)
    );

    func_sweep_tester #(.SETTLE_CYCLES(0), .EXPECTED(8'hF2)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .f_in(f0),
        .x_out(x0), .y_out(y0), .z_out(z0), .busy(busy0), .done(done0),
        .pass(pass0), .table_out(table0),
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
        .first_fail_vld(ffv0), .first_fail_idx(ffi0),
`endif
        .mism_cnt(mism0)
    );

    // Observation mux: sel_v 0 = settle-2 instance, 1 = settle-0 instance
    int         sel_v = 0;
    logic       o_done, o_busy, o_pass;
    logic [7:0] o_table;
    logic [3:0] o_mism;
    logic [2:0] o_vec;
    logic       o_ffv;
    logic [2:0] o_ffi;
    always_comb begin
        o_ffv = 1'b0;
        o_ffi = 3'd0;
        if (sel_v == 0) begin
            o_done = done2; o_busy = busy2; o_pass = pass2;
            o_table = table2; o_mism = mism2; o_vec = {x2, y2, z2};
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
            o_ffv = ffv2; o_ffi = ffi2;
`endif
        end else begin
            o_done = done0; o_busy = busy0; o_pass = pass0;
            o_table = table0; o_mism = mism0; o_vec = {x0, y0, z0};
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
            o_ffv = ffv0; o_ffi = ffi0;
`endif
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int         sel;
        logic [1:0] mode;
        int         lat;
        logic [7:0] tbl;
        int         mism;
        int         pass;
        int         ffv;
        int         ffi;
    } vec_t;

    vec_t vecs[7];

    // Pulse start, track the sweep to done, then check the results and the idle cycle after.
    task automatic do_vec(input vec_t v);
        int lat, vec_bad, busy_bad, per;
        sel_v = v.sel;
        per = (v.sel == 0) ? 3 : 1;
        if (v.sel == 0) mode2 = v.mode; else mode0 = v.mode;
        @(negedge clk);
        if (v.sel == 0) start2 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        start0 = 1'b0;
        lat = 1;
        vec_bad = 0;
        busy_bad = 0;
        check("cleared_at_start", int'({o_table, o_mism, o_pass}), 0);
        while (!o_done && lat < 200) begin
            if (o_vec != 3'((lat - 1) / per)) vec_bad++;
            if (!o_busy) busy_bad++;
            @(negedge clk);
            lat++;
        end
        check("done_latency", lat, v.lat);
        check("vector_sequence_errs", vec_bad, 0);
        check("busy_gaps", busy_bad, 0);
        check("busy_at_done", int'(o_busy), 0);
        check("table_out", int'(o_table), int'(v.tbl));
        check("mism_cnt", int'(o_mism), v.mism);
        check("pass", int'(o_pass), v.pass);
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
        check("first_fail_vld", int'(o_ffv), v.ffv);
        check("first_fail_idx", int'(o_ffi), v.ffi);
`endif
        @(negedge clk);
        check("done_one_cycle", int'(o_done), 0);
        check("vec_hold_111", int'(o_vec), 7);
        check("table_held", int'(o_table), int'(v.tbl));
        check("pass_held", int'(o_pass), v.pass);
    endtask

    initial begin
        int lat, dcount;
        vecs[0] = '{0, 2'd0, 25, 8'hF2, 0, 1, 0, 0};
        vecs[1] = '{0, 2'd1, 25, 8'h00, 5, 0, 1, 1};
        vecs[2] = '{0, 2'd0, 25, 8'hF2, 0, 1, 0, 0};
        vecs[3] = '{1, 2'd0,  9, 8'hF2, 0, 1, 0, 0};
        vecs[4] = '{1, 2'd2,  9, 8'hFF, 3, 0, 1, 0};
        vecs[5] = '{1, 2'd3,  9, 8'h0D, 8, 0, 1, 0};
        vecs[6] = '{0, 2'd3, 25, 8'h0D, 8, 0, 1, 0};

        rst = 1'b1; start2 = 1'b0; start0 = 1'b0; mode2 = 2'd0; mode0 = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sel_v = 0;
        #1;
        check("reset_outputs", int'({o_busy, o_done, o_pass, o_table, o_mism, o_vec}), 0);
        sel_v = 1;
        #1;
        check("reset_outputs_s0", int'({o_busy, o_done, o_pass, o_table, o_mism, o_vec}), 0);

        for (int i = 0; i < 7; i++) begin
            do_vec(vecs[i]);
        end

        // start re-pulsed mid-sweep (idx 3) and on the done cycle: both ignored
        sel_v = 0;
        mode2 = 2'd0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 200) begin
            start2 = (lat == 10);
            @(negedge clk);
            lat++;
        end
        check("repulse_latency", lat, 25);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("repulse_done_low", int'(done2), 0);
        check("repulse_idle_busy", int'(busy2), 0);
        dcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (done2 || busy2) dcount++;
        end
        check("repulse_no_restart", dcount, 0);
        check("repulse_table", int'(table2), 8'hF2);
        check("repulse_pass", int'(pass2), 1);

        // rst during SAMPLE of idx 5, then a clean sweep
        mode2 = 2'd1;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (lat < 18) begin
            @(negedge clk);
            lat++;
        end
        check("rst_at_idx5", int'({x2, y2, z2}), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_sweep", int'({busy2, done2, pass2, table2, mism2, x2, y2, z2}), 0);
`ifdef FUNC_SWEEP_FIRST_FAIL_EN
        check("rst_first_fail", int'({ffv2, ffi2}), 0);
`endif
        do_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
